ext_pipe: RTL and testbench



---
 rtl/ext_pkg.sv | 19 +
 rtl/ext_core.sv | 11 +
 rtl/ext_pipe.sv | 53 +++++
 tb/tb_ext_pipe.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: extension opcodes and the shared width-generic extension function.
package ext_pkg;
  localparam logic [1:0] EOP_ZERO = 2'b00;
  localparam logic [1:0] EOP_SIGN = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_BOFF = 2'b11;
  // Works on 64-bit containers so one function serves every IMM_W/OUT_W pairing.
  function automatic logic [63:0] ext_calc(input logic [63:0] imm, input logic [1:0] eop,
                                           input int imm_w, input int out_w);
    logic [63:0] mi, i, sx, r;
    mi = (64'd1 << imm_w) - 64'd1;
    i  = imm & mi;
    sx = (i & (64'd1 << (imm_w - 1))) != 64'd0 ? (i | ~mi) : i;
    r  = eop == EOP_ZERO ? i :
         eop == EOP_SIGN ? sx :
         eop == EOP_LUI  ? i << (out_w - imm_w) : sx << 2;
    return out_w >= 64 ? r : r & ((64'd1 << out_w) - 64'd1);
  endfunction
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender.
module ext_core import ext_pkg::*; #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       eop,
  output logic [OUT_W-1:0] ext
);
  assign ext = OUT_W'(ext_calc(64'(imm), eop, IMM_W, OUT_W));
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: immediate extender feeding a DEPTH-entry result FIFO with
// valid/ready on both sides; all handshake outputs come from registered state.
module ext_pipe import ext_pkg::*; #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       EOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [CNT_W-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] ext;
  logic             push, pop;
  ext_core #(.IMM_W(IMM_W), .OUT_W(OUT_W)) u_core (.imm(imm), .eop(EOp), .ext(ext));
  assign in_ready  = count_q != CNT_W'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_ext   = mem_q[rd_ptr_q];
  assign count     = count_q;
  // Explicit wrap: DEPTH need not be a power of two.
  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    wr_ptr_d = push ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = push && !pop ? count_q + 1'b1 : !push && pop ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ext;
  end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: table vectors plus randomized traffic against a queue model,
// on a default instance and an 8->16 bit, depth-3 instance.
module tb_ext_pipe;
  import ext_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic a_iv, a_ir, a_ov, a_or;
  logic [15:0] a_imm;
  logic [1:0]  a_eop;
  logic [31:0] a_ext;
  logic [2:0]  a_cnt;
  logic b_iv, b_ir, b_ov, b_or;
  logic [7:0]  b_imm;
  logic [1:0]  b_eop;
  logic [15:0] b_ext;
  logic [1:0]  b_cnt;
  ext_pipe dut_a (.clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .imm(a_imm),
                  .EOp(a_eop), .out_valid(a_ov), .out_ready(a_or), .out_ext(a_ext), .count(a_cnt));
  ext_pipe #(.IMM_W(8), .OUT_W(16), .DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .imm(b_imm),
    .EOp(b_eop), .out_valid(b_ov), .out_ready(b_or), .out_ext(b_ext), .count(b_cnt));
  int n_cmp = 0, n_bad = 0;
  logic [31:0] qa[$];
  logic [15:0] qb[$];
  typedef struct {logic [15:0] imm; logic [1:0] eop; logic [31:0] exp;} vec_t;
  vec_t va[6];
  vec_t vb[4];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step_a(input string tag);
    bit acc, pop;
    logic [31:0] e;
    chk({tag, " a count"}, 64'(a_cnt), 64'(qa.size()));
    chk({tag, " a in_ready"}, 64'(a_ir), 64'(qa.size() != 4));
    chk({tag, " a out_valid"}, 64'(a_ov), 64'(qa.size() != 0));
    if (qa.size() != 0) chk({tag, " a out_ext"}, 64'(a_ext), 64'(qa[0]));
    acc = a_iv && qa.size() != 4;
    pop = a_or && qa.size() != 0;
    e = 32'(ext_calc(64'(a_imm), a_eop, 16, 32));
    @(posedge clk);
    if (pop) void'(qa.pop_front());
    if (acc) qa.push_back(e);
    @(negedge clk);
  endtask
  task automatic step_b(input string tag);
    bit acc, pop;
    logic [15:0] e;
    chk({tag, " b count"}, 64'(b_cnt), 64'(qb.size()));
    chk({tag, " b in_ready"}, 64'(b_ir), 64'(qb.size() != 3));
    chk({tag, " b out_valid"}, 64'(b_ov), 64'(qb.size() != 0));
    if (qb.size() != 0) chk({tag, " b out_ext"}, 64'(b_ext), 64'(qb[0]));
    acc = b_iv && qb.size() != 3;
    pop = b_or && qb.size() != 0;
    e = 16'(ext_calc(64'(b_imm), b_eop, 8, 16));
    @(posedge clk);
    if (pop) void'(qb.pop_front());
    if (acc) qb.push_back(e);
    @(negedge clk);
  endtask
  initial begin
    va[0] = '{16'hf111, 2'b00, 32'h0000f111};
    va[1] = '{16'hf111, 2'b01, 32'hfffff111};
    va[2] = '{16'hf111, 2'b10, 32'hf1110000};
    va[3] = '{16'hf111, 2'b11, 32'hffffc444};
    va[4] = '{16'h7fff, 2'b01, 32'h00007fff};
    va[5] = '{16'h7fff, 2'b11, 32'h0001fffc};
    vb[0] = '{16'h0080, 2'b00, 32'h00000080};
    vb[1] = '{16'h0080, 2'b01, 32'h0000ff80};
    vb[2] = '{16'h0080, 2'b10, 32'h00008000};
    vb[3] = '{16'h0080, 2'b11, 32'h0000fe00};
    reset = 1'b0;
    {a_iv, a_or, a_imm, a_eop} = '0;
    {b_iv, b_or, b_imm, b_eop} = '0;
    repeat (2) @(negedge clk);
    chk("reset a count", 64'(a_cnt), 64'd0);
    chk("reset a out_valid", 64'(a_ov), 64'd0);
    chk("reset a in_ready", 64'(a_ir), 64'd1);
    reset = 1'b1;
    // Table vectors: accept, result visible one cycle later, then drained.
    for (int k = 0; k < 6; k++) begin
      a_iv = 1'b1; a_or = 1'b1; a_imm = va[k].imm; a_eop = va[k].eop;
      step_a("vec push");
      a_iv = 1'b0;
      chk($sformatf("vec%0d a out_valid", k), 64'(a_ov), 64'd1);
      chk($sformatf("vec%0d a out_ext", k), 64'(a_ext), 64'(va[k].exp));
      step_a("vec pop");
    end
    // Fill with consumer stalled; fifth push must be refused.
    a_or = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_iv = 1'b1; a_imm = 16'(k * 16'h1111 + 1); a_eop = 2'(k);
      step_a("fill");
    end
    chk("full a in_ready", 64'(a_ir), 64'd0);
    chk("full a count", 64'(a_cnt), 64'd4);
    a_iv = 1'b1; a_or = 1'b1;
    step_a("full push+pop");
    a_iv = 1'b0;
    repeat (4) step_a("drain");
    chk("drained a out_valid", 64'(a_ov), 64'd0);
    // Streaming at one result per cycle.
    a_iv = 1'b1; a_or = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_imm = 16'($urandom); a_eop = 2'($urandom);
      step_a("stream");
      chk("stream a count", 64'(a_cnt), 64'd1);
    end
    a_iv = 1'b0;
    step_a("stream end");
    // Asynchronous reset mid-stream with three results buffered.
    a_or = 1'b0; a_iv = 1'b1;
    repeat (3) begin
      a_imm = 16'($urandom); a_eop = 2'($urandom);
      step_a("pre-reset");
    end
    a_iv = 1'b0;
    chk("pre-reset a count", 64'(a_cnt), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("async a count", 64'(a_cnt), 64'd0);
    chk("async a out_valid", 64'(a_ov), 64'd0);
    chk("async a in_ready", 64'(a_ir), 64'd1);
    qa.delete();
    @(negedge clk);
    reset = 1'b1;
    a_iv = 1'b1; a_imm = 16'h0001; a_eop = 2'b10;
    step_a("post-reset");
    a_iv = 1'b0;
    chk("post-reset a out_ext", 64'(a_ext), 64'h00010000);
    a_or = 1'b1;
    step_a("post-reset pop");
    for (int k = 0; k < 300; k++) begin
      a_iv = 1'($urandom); a_or = 1'($urandom_range(0, 2) != 0);
      a_imm = 16'($urandom); a_eop = 2'($urandom);
      step_a("rand");
    end
    a_iv = 1'b0; a_or = 1'b0;
    // Narrow instance, non-power-of-two depth.
    for (int k = 0; k < 4; k++) begin
      b_iv = 1'b1; b_or = 1'b1; b_imm = vb[k].imm[7:0]; b_eop = vb[k].eop;
      step_b("vec push");
      b_iv = 1'b0;
      chk($sformatf("vec%0d b out_ext", k), 64'(b_ext), 64'(vb[k].exp));
      step_b("vec pop");
    end
    b_or = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_iv = 1'b1; b_imm = 8'(k * 37 + 5); b_eop = 2'(k);
      step_b("fill");
    end
    chk("full b in_ready", 64'(b_ir), 64'd0);
    chk("full b count", 64'(b_cnt), 64'd3);
    b_iv = 1'b0; b_or = 1'b1;
    repeat (3) step_b("drain");
    for (int k = 0; k < 300; k++) begin
      b_iv = 1'($urandom); b_or = 1'($urandom_range(0, 2) != 0);
      b_imm = 8'($urandom); b_eop = 2'($urandom);
      step_b("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
